// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: read-owner tag, arbitration state, word offset.
package dmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DBG
    } owner_t;

    typedef enum logic {
        CORE_PRI,
        DBG_FORCE
    } arb_state_t;

    localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates one single-port data memory between the core load/store port and a debug port.
// Latency: grant is combinational; read data returns one cycle after the grant, tagged by a registered owner.
// Backpressure: the core sees core_stall and holds its request; debug holds dbg_req until dbg_gnt.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_be,
    output logic                core_stall,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_rvalid,

    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_gnt,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                dbg_rvalid,

    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [31:0]         stall_cycles
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    arb_state_t  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    owner_t      owner_q, owner_d;
    logic [31:0] stall_cnt_q;
    logic        core_grant;
    logic        dbg_grant;

    // Byte offset bits are not used for word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[WORD_OFFSET-1:0], dbg_addr[WORD_OFFSET-1:0]};

    // Grants are suppressed while reset is held so no write can reach the memory.
    always_comb begin
        core_grant = 1'b0;
        dbg_grant  = 1'b0;
        state_d    = state_q;
        wait_d     = wait_q;

        case (state_q)
            CORE_PRI: begin
                core_grant = core_req & rst;
                dbg_grant  = dbg_req & ~core_req & rst;
            end
            DBG_FORCE: begin
                dbg_grant  = dbg_req & rst;
                core_grant = core_req & ~dbg_req & rst;
            end
            default: begin
                core_grant = 1'b0;
                dbg_grant  = 1'b0;
            end
        endcase

        if (!dbg_req || dbg_grant) begin
            wait_d = 4'd0;
        end else begin
            wait_d = wait_q + 4'd1;
        end

        case (state_q)
            CORE_PRI:  if (wait_d == MAX_WAIT_C)     state_d = DBG_FORCE;
            DBG_FORCE: if (dbg_grant || !dbg_req)    state_d = CORE_PRI;
            default:                                 state_d = CORE_PRI;
        endcase
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (core_grant && !core_we) begin
            owner_d = OWN_CORE;
        end else if (dbg_grant && !dbg_we) begin
            owner_d = OWN_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CORE_PRI;
            wait_q      <= 4'd0;
            owner_q     <= OWN_NONE;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            owner_q <= owner_d;
            if (core_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign core_stall   = core_req & ~core_grant;
    assign dbg_gnt      = dbg_grant;
    assign stall_cycles = stall_cnt_q;

    assign mem_en    = core_grant | dbg_grant;
    assign mem_we    = dbg_grant ? dbg_we : (core_grant & core_we);
    assign mem_addr  = dbg_grant ? dbg_addr[ADDR_W-1:WORD_OFFSET] : core_addr[ADDR_W-1:WORD_OFFSET];
    assign mem_wdata = dbg_grant ? dbg_wdata : core_wdata;
    assign mem_be    = dbg_grant ? {(DATA_W/8){1'b1}} : core_be;

    // Both read buses share the memory output; the owner tag decides who sees a valid.
    assign core_rdata  = mem_rdata;
    assign dbg_rdata   = mem_rdata;
    assign core_rvalid = (owner_q == OWN_CORE);
    assign dbg_rvalid  = (owner_q == OWN_DBG);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model behind the mem_* port.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_be;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_be(core_be), .core_stall(core_stall),
        .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall_cycles(stall_cycles)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[7:0]];
            end
        end
    end

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_be = 4'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL reset_core_rvalid got=%b exp=0", core_rvalid); end
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dbg_rvalid got=%b exp=0", dbg_rvalid); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got=%h exp=0", stall_cycles); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (dut.state_q !== CORE_PRI) begin errors++; $display("FAIL reset_state got=%0d exp=CORE_PRI", dut.state_q); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_core_only();
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'hDEADBEEF; core_be = 4'hF;
        #1;
        checks++; if ({mem_en, mem_we, core_stall} !== 3'b110) begin errors++; $display("FAIL core_st_ctrl got=%b exp=110", {mem_en, mem_we, core_stall}); end
        checks++; if (mem_addr !== 30'h40) begin errors++; $display("FAIL core_st_addr got=%h exp=40", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF || mem_be !== 4'hF) begin errors++; $display("FAIL core_st_data got=%h/%h exp=deadbeef/f", mem_wdata, mem_be); end
        @(negedge clk);
        core_we = 1'b0;
        #1;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL core_st_no_rvalid got=%b exp=0", core_rvalid); end
        checks++; if (mem_addr !== 30'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL core_ld_addr got=%h/%b exp=40/0", mem_addr, mem_we); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_ld_data got=%b/%h exp=1/deadbeef", core_rvalid, core_rdata); end
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL core_ld_dbg_rvalid got=%b exp=0", dbg_rvalid); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL core_stall_cycles got=%h exp=0", stall_cycles); end
        @(negedge clk);
        #1;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL core_rvalid_pulse got=%b exp=0", core_rvalid); end
    endtask

    task automatic test_dbg_only();
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1FC; dbg_wdata = 32'h12345678;
        #1;
        checks++; if ({dbg_gnt, mem_en, mem_we} !== 3'b111) begin errors++; $display("FAIL dbg_wr_ctrl got=%b exp=111", {dbg_gnt, mem_en, mem_we}); end
        checks++; if (mem_be !== 4'hF || mem_addr !== 30'h7F) begin errors++; $display("FAIL dbg_wr_be_addr got=%h/%h exp=f/7f", mem_be, mem_addr); end
        @(negedge clk);
        dbg_we = 1'b0;
        #1;
        checks++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL dbg_rd_gnt got=%b/%b exp=1/0", dbg_gnt, mem_we); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h12345678) begin errors++; $display("FAIL dbg_rd_data got=%b/%h exp=1/12345678", dbg_rvalid, dbg_rdata); end
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL dbg_rd_core_rvalid got=%b exp=0", core_rvalid); end
    endtask

    task automatic test_contention();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1FC;
            #1;
            checks++;
            if (dbg_gnt !== (i == 5) || core_stall !== (i == 5)) begin
                errors++; $display("FAIL contention_cycle%0d got gnt=%b stall=%b exp=%b", i, dbg_gnt, core_stall, (i == 5));
            end
        end
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        checks++; if (core_stall !== 1'b0 || mem_addr !== 30'h40) begin errors++; $display("FAIL contention_core_resume got=%b/%h exp=0/40", core_stall, mem_addr); end
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL contention_stall_cycles got=%h exp=1", stall_cycles); end
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h12345678) begin errors++; $display("FAIL contention_dbg_data got=%b/%h exp=1/12345678", dbg_rvalid, dbg_rdata); end
        checks++; if (dut.state_q !== CORE_PRI) begin errors++; $display("FAIL contention_state got=%0d exp=CORE_PRI", dut.state_q); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_interleaved();
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'hA5A50000;
        @(negedge clk);
        dbg_addr = 32'h4; dbg_wdata = 32'h00005A5A;
        @(negedge clk);
        idle_inputs();
        // Four contention cycles; the fourth core read is cycle N.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
        end
        #1;
        checks++; if (dbg_gnt !== 1'b0 || mem_addr !== 30'h0) begin errors++; $display("FAIL inter_cycleN got=%b/%h exp=0/0", dbg_gnt, mem_addr); end
        @(negedge clk);
        #1;
        checks++; if (dbg_gnt !== 1'b1 || core_stall !== 1'b1 || mem_addr !== 30'h1) begin errors++; $display("FAIL inter_force got=%b/%b/%h exp=1/1/1", dbg_gnt, core_stall, mem_addr); end
        checks++; if (core_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || core_rdata !== 32'hA5A50000) begin errors++; $display("FAIL inter_core_rd got=%b/%b/%h exp=1/0/a5a50000", core_rvalid, dbg_rvalid, core_rdata); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (dbg_rvalid !== 1'b1 || core_rvalid !== 1'b0 || dbg_rdata !== 32'h00005A5A) begin errors++; $display("FAIL inter_dbg_rd got=%b/%b/%h exp=1/0/00005a5a", dbg_rvalid, core_rvalid, dbg_rdata); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL inter_stall_cycles got=%h exp=2", stall_cycles); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        #1;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_grant got=%b exp=1", mem_en); end
        @(posedge clk);
        rst = 1'b0;
        core_we = 1'b1; core_wdata = 32'hBAD0BAD0; core_be = 4'hF;
        #1;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got=%b exp=0", core_rvalid); end
        checks++; if (stall_cycles !== 32'd0 || dut.state_q !== CORE_PRI) begin errors++; $display("FAIL rstmid_state got=%h/%0d exp=0/CORE_PRI", stall_cycles, dut.state_q); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_no_write got=%b/%b exp=0/0", mem_en, mem_we); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (mem[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_mem_intact got=%h exp=deadbeef", mem[8'h40]); end
    endtask

    task automatic test_saturation();
        int stalls;
        stalls = 0;
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1FC;
            #1;
            if (core_stall === 1'b1) stalls++;
            if (i == 6) begin
                checks++; if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first got=%h exp=ffffffff", stall_cycles); end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (stalls != 3) begin errors++; $display("FAIL sat_stall_count got=%0d exp=3", stalls); end
        checks++; if (stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cycles); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        test_reset();
        test_core_only();
        test_dbg_only();
        test_contention();
        test_interleaved();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
